// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state codes, SPI mode constants and sizing helpers
// for the spi_master initiator.
package spi_pkg;
    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t LEAD  = 3'd1;
    localparam state_t SHIFT = 3'd2;
    localparam state_t WAIT  = 3'd3;
    localparam state_t TRAIL = 3'd4;
    localparam state_t GAP   = 3'd5;
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b1;
    function automatic int edge_w(input int width);
        return $clog2(2 * width);
    endfunction
endpackage

// File: rtl/spi_master_clkgen.sv
// spi_master_clkgen: half-period divider producing the tick strobe and the
// SCK toggle register; clr restarts the half-period, en allows SCK to toggle.
module spi_master_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o,
    output logic sck_o
);
    import spi_pkg::*;
    localparam int DW = $clog2(CLK_DIV);
    logic [DW-1:0] div_q, div_d;
    logic sck_q, sck_d;
    assign tick_o = div_q == DW'(CLK_DIV - 1);
    assign sck_o  = sck_q;
    always_comb begin
        div_d = (clr_i || tick_o) ? '0 : div_q + DW'(1);
        sck_d = clr_i ? CPOL : (en_i && tick_o) ? ~sck_q : sck_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            sck_q <= CPOL;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: CPOL=0/CPHA=1 MSB-first SPI initiator with valid/ready tx,
// pulsed rx and multi-word bursts held under a single SS assertion.
module spi_master #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SS_I,
    output logic             SS_O,
    output logic             SS_T,
    input  logic             SCK_I,
    output logic             SCK_O,
    output logic             SCK_T,
    input  logic             IO0_I,
    output logic             IO0_O,
    output logic             IO0_T,
    input  logic             IO1_I,
    output logic             IO1_O,
    output logic             IO1_T,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_last,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);
    import spi_pkg::*;
    localparam int EW = edge_w(WIDTH);
    state_t state_q, state_d;
    logic ss_q, ss_d, io0_q, io0_d, rx_valid_q, rx_valid_d;
    logic tx_ready_q, tx_ready_d, last_q, last_d;
    logic [WIDTH-1:0] tx_sr_q, tx_sr_d, rx_data_q, rx_data_d;
    logic [WIDTH-2:0] rx_sr_q, rx_sr_d;
    logic [EW-1:0] edge_q, edge_d;
    logic tick, accept, in_shift, drive, sample, done;
    logic unused_in;
    assign unused_in = ^{SS_I, SCK_I, IO0_I};
    assign {SS_T, SCK_T, IO0_T, IO1_O, IO1_T} = 5'b00001;
    assign SS_O     = ss_q;
    assign IO0_O    = io0_q;
    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = state_q != IDLE;
    assign accept   = tx_valid && tx_ready_q;
    assign in_shift = state_q == SHIFT;
    // Even edges are leading (drive MOSI), odd edges trailing (sample MISO).
    assign drive    = in_shift && tick && (edge_q[0] == ~CPHA);
    assign sample   = in_shift && tick && (edge_q[0] == CPHA);
    assign done     = sample && edge_q == EW'(2 * WIDTH - 1);
    spi_master_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_d != state_q),
        .en_i   (in_shift),
        .tick_o (tick),
        .sck_o  (SCK_O)
    );
    always_comb begin
        case (state_q)
            IDLE:    state_d = accept ? LEAD : IDLE;
            LEAD:    state_d = tick ? SHIFT : LEAD;
            SHIFT:   state_d = done ? (last_q ? TRAIL : WAIT) : SHIFT;
            WAIT:    state_d = accept ? SHIFT : WAIT;
            TRAIL:   state_d = tick ? GAP : TRAIL;
            GAP:     state_d = tick ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        tx_ready_d = state_d == IDLE || state_d == WAIT;
        ss_d       = state_d == IDLE || state_d == GAP;
        edge_d     = (in_shift && state_d == SHIFT) ? edge_q + EW'(tick) : '0;
        tx_sr_d    = accept ? tx_data : drive ? {tx_sr_q[WIDTH-2:0], 1'b0} : tx_sr_q;
        io0_d      = drive ? tx_sr_q[WIDTH-1] : io0_q;
        rx_sr_d    = sample ? {rx_sr_q[WIDTH-3:0], IO1_I} : rx_sr_q;
        rx_data_d  = done ? {rx_sr_q, IO1_I} : rx_data_q;
        rx_valid_d = done;
        last_d     = accept ? tx_last : last_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ss_q       <= 1'b1;
            io0_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            last_q     <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            edge_q     <= '0;
        end else begin
            state_q    <= state_d;
            ss_q       <= ss_d;
            io0_q      <= io0_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            last_q     <= last_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            edge_q     <= edge_d;
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized transfers against a bus-level slave model that
// reconstructs MOSI words and supplies MISO words, plus a 32-bit loopback DUT.
module tb_spi_master;
    localparam int W = 8, D = 4, WB = 32, DB = 2;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic ss, sck, mosi, miso = 1'b0, ss_t, sck_t, io0_t, io1_o, io1_t;
    logic [W-1:0] tx_data = '0, rx_data;
    logic tx_last = 1'b0, tx_valid = 1'b0, tx_ready, rx_valid, busy;
    spi_master #(.WIDTH(W), .CLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .SS_I(1'b1), .SS_O(ss), .SS_T(ss_t),
        .SCK_I(1'b0), .SCK_O(sck), .SCK_T(sck_t),
        .IO0_I(1'b0), .IO0_O(mosi), .IO0_T(io0_t),
        .IO1_I(miso), .IO1_O(io1_o), .IO1_T(io1_t),
        .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
    );

    logic ssb, sckb, mosib, busyb, txb_ready, rxb_valid, txb_valid = 1'b0;
    logic [4:0] b_t;
    logic [WB-1:0] txb_data = '0, rxb_data;
    spi_master #(.WIDTH(WB), .CLK_DIV(DB)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .SS_I(1'b1), .SS_O(ssb), .SS_T(b_t[0]),
        .SCK_I(1'b0), .SCK_O(sckb), .SCK_T(b_t[1]),
        .IO0_I(1'b0), .IO0_O(mosib), .IO0_T(b_t[2]),
        .IO1_I(mosib), .IO1_O(b_t[3]), .IO1_T(b_t[4]),
        .tx_data(txb_data), .tx_last(1'b1), .tx_valid(txb_valid), .tx_ready(txb_ready),
        .rx_data(rxb_data), .rx_valid(rxb_valid), .busy(busyb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model: shifts its word out on rising SCK, captures MOSI on falling SCK.
    logic [W-1:0] exp_tx[$], exp_rx[$], slave_q[$];
    logic [W-1:0] mosi_sr = '0, slave_cur = '0;
    logic ss_p = 1'b1, sck_p = 1'b0, gap_ready_bad = 1'b0;
    int ss_len = 0, rises = 0, rxs = 0, rx_total = 0, ss_rise_cnt = 0, nedge = 0;
    int hi_len = 100, last_hi = 0, acc_cyc = 0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            ss_p = 1'b1; sck_p = 1'b0; nedge = 0; miso = 1'b0;
        end else begin
            if (ss_p && !ss) begin ss_len = 0; rises = 0; rxs = 0; last_hi = hi_len; end
            if (!ss_p && ss) begin ss_rise_cnt++; hi_len = 0; end
            if (!ss) ss_len++;
            else begin
                if (hi_len < D && tx_ready) gap_ready_bad = 1'b1;
                hi_len++;
            end
            if (!sck_p && sck) begin
                rises++;
                if (nedge % W == 0) slave_cur = slave_q.size() > 0 ? slave_q.pop_front() : W'($urandom);
                miso = slave_cur[W - 1 - nedge % W];
            end
            if (sck_p && !sck) begin
                mosi_sr = {mosi_sr[W-2:0], mosi};
                nedge++;
                if (nedge % W == 0) check("mosi_word", 32'(mosi_sr), exp_tx.size() > 0 ? 32'(exp_tx.pop_front()) : 32'bx);
            end
            if (rx_valid) begin
                rxs++; rx_total++;
                check("rx_data", 32'(rx_data), exp_rx.size() > 0 ? 32'(exp_rx.pop_front()) : 32'bx);
            end
            ss_p = ss; sck_p = sck;
        end
    end

    logic sckb_p = 1'b0;
    int b_prev = -1000, b_period = 0;
    initial forever begin
        @(negedge clk);
        if (!sckb_p && sckb) begin
            if (cyc - b_prev < 100) b_period = cyc - b_prev;
            b_prev = cyc;
        end
        sckb_p = sckb;
    end

    task automatic send(input logic [W-1:0] d, input logic l, input logic [W-1:0] s);
        int n = 0;
        exp_tx.push_back(d); exp_rx.push_back(s); slave_q.push_back(s);
        @(negedge clk);
        tx_data = d; tx_last = l; tx_valid = 1'b1;
        while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
        check("accept_timeout", 32'(n < 2000), 1);
        @(posedge clk); #1;
        acc_cyc = cyc; tx_valid = 1'b0; tx_data = W'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 3000);
        check("idle_timeout", 32'(n < 3000), 1);
    endtask

    task automatic wait_wait();
        int n = 0;
        do begin @(negedge clk); n++; end while (!(busy && tx_ready) && n < 3000);
        check("wait_timeout", 32'(n < 3000), 1);
    endtask

    task automatic rise_delay(input string tag, input int exp);
        int n = 0;
        while (!sck && n < 500) begin @(negedge clk); n++; end
        check(tag, cyc - acc_cyc, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a1, r0, n;
        bit st;
        logic [WB-1:0] wb;
        repeat (3) @(negedge clk);
        check("rst_ss", ss, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("tristate_consts", 32'({ss_t, sck_t, io0_t, io1_o, io1_t}), 32'b00001);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", tx_ready, 1);

        send(8'hA5, 1'b1, 8'h3C);
        rise_delay("first_rise_from_idle", 2 * D);
        wait_idle();
        check("single_ss_len", ss_len, (2 * W + 2) * D);
        check("single_rises", rises, W);
        check("single_rx_pulses", rxs, 1);
        check("mosi_hold_after", mosi, 1);

        r0 = ss_rise_cnt;
        send(8'h12, 1'b0, 8'hAB);
        send(8'h34, 1'b1, 8'hCD);
        wait_idle();
        check("burst_ss_len", ss_len, (4 * W + 2) * D + 1);
        check("burst_rises", rises, 2 * W);
        check("burst_rx_pulses", rxs, 2);
        check("burst_ss_rises", ss_rise_cnt - r0, 1);

        send(W'($urandom), 1'b0, W'($urandom));
        wait_wait();
        repeat (50) @(negedge clk);
        check("wait_ss", ss, 0);
        check("wait_sck", sck, 0);
        check("wait_ready", tx_ready, 1);
        check("wait_busy", busy, 1);
        send(W'($urandom), 1'b1, W'($urandom));
        rise_delay("resume_rise", D);
        wait_idle();
        check("stall_rises", rises, 2 * W);

        gap_ready_bad = 1'b0;
        send(8'hFF, 1'b1, W'($urandom));
        a1 = acc_cyc;
        send(8'h00, 1'b1, W'($urandom));
        check("accept_spacing", acc_cyc - a1, (2 * W + 3) * D + 1);
        wait_idle();
        check("gap_len_min", 32'(last_hi >= D), 1);
        check("gap_ready_low", gap_ready_bad, 0);
        check("mosi_hold_zero", mosi, 0);

        r0 = rx_total;
        send(W'($urandom), 1'b1, W'($urandom));
        n = 0;
        while (nedge < 3 && n < 1000) begin @(negedge clk); n++; end
        @(posedge sck); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ss", ss, 1);
        check("midrst_sck", sck, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rx_data", 32'(rx_data), 0);
        exp_tx.delete(); exp_rx.delete(); slave_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4 * D) @(negedge clk);
        check("midrst_no_rx", rx_total - r0, 0);
        send(8'h5A, 1'b1, W'($urandom));
        wait_idle();
        check("post_rst_rises", rises, W);
        check("post_rst_rx", rxs, 1);

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 3);
            st = ($urandom_range(0, 1) == 1) && n > 1;
            for (int k = 0; k < n; k++) begin
                if (st && k > 0) begin
                    wait_wait();
                    repeat ($urandom_range(1, 20)) @(negedge clk);
                end
                send(W'($urandom), k == n - 1, W'($urandom));
            end
            wait_idle();
            check("rand_rises", rises, W * n);
            check("rand_rx_pulses", rxs, n);
            if (!st) check("rand_ss_len", ss_len, (2 * W * n + 2) * D + n - 1);
        end
        check("queues_drained", exp_tx.size() + exp_rx.size(), 0);

        for (int k = 0; k < 3; k++) begin
            wb = (k == 0) ? 32'hDEADBEEF : $urandom;
            @(negedge clk);
            txb_data = wb; txb_valid = 1'b1;
            n = 0;
            while (!txb_ready && n < 500) begin @(negedge clk); n++; end
            @(posedge clk); #1;
            txb_valid = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!rxb_valid && n < 2000);
            check("b_loopback", rxb_data, wb);
            check("b_sck_period", b_period, 2 * DB);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI initiator: the counterpart of the team's spi_slave core, with the same fixed mode CPOL=0, CPHA=1, MSB first. Serialises WIDTH-bit words from a valid/ready stream onto MOSI (IO0) and captures MISO (IO1) into an rx word stream. Generates SS and SCK from the system clock. Bursts are supported: SS stays low across words until a word flagged last completes. It sits between FPGA control logic and external SPI slaves, including our own spi_slave.

Parameters:
WIDTH, 8, word length in bits (8, 16, 24 or 32).
CLK_DIV, 4, SCK half-period in clk cycles, must be ≥2. SCK frequency is clk/(2*CLK_DIV).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
SS_I  in  1  unused
SS_O  out  1  slave select, active-low
SS_T  out  1  constant 0 (driven)
SCK_I  in  1  unused
SCK_O  out  1  serial clock, idle low
SCK_T  out  1  constant 0
IO0_I  in  1  unused
IO0_O  out  1  MOSI
IO0_T  out  1  constant 0
IO1_I  in  1  MISO
IO1_O  out  1  constant 0
IO1_T  out  1  constant 1 (input)
tx_data  in  WIDTH  word to send
tx_last  in  1  deassert SS after this word
tx_valid  in  1  tx word valid
tx_ready  out  1  tx word accepted when valid&&ready
rx_data  out  WIDTH  word received during the last shift
rx_valid  out  1  one-cycle pulse, rx_data valid
busy  out  1  high whenever state≠IDLE

Behaviour:
- Reset (rst_n low, async) values: SS_O=1, SCK_O=0, IO0_O=0, rx_data=0, rx_valid=0, tx_ready=0, busy=0, state=IDLE, all counters 0. On the first clk edge after release, tx_ready=1.
- Half-period tick: div_cnt counts 0..CLK_DIV-1 and is cleared on every state entry. tick = (div_cnt==CLK_DIV-1).
- tx_ready is registered and is 1 only in IDLE and WAIT. An accept loads tx_data into tx_sr and latches tx_last.
- FSM states:
  - IDLE: SS_O=1. On accept, go to LEAD and drive SS_O=0 on the next cycle.
  - LEAD: lasts one half-period (CLK_DIV cycles) with SS low and SCK low, then go to SHIFT.
  - SHIFT: edge_cnt counts 0..2*WIDTH-1, and SCK_O toggles on each tick.
    - Even edge (rising): IO0_O ← tx_sr[MSB], then tx_sr shifts left.
    - Odd edge (falling): rx_sr ← {rx_sr[WIDTH-2:0], IO1_I}.
    - After the final falling edge: rx_data ← the completed word, rx_valid=1 for exactly one cycle. Then go to TRAIL if last was latched, otherwise WAIT.
  - WAIT: SS low, SCK low, tx_ready=1. The block may stall here indefinitely. On accept, go directly to SHIFT; the first rising edge occurs CLK_DIV cycles later.
  - TRAIL: one half-period with SS low, then SS_O=1 and go to GAP.
  - GAP: one half-period with SS high (minimum deselect time), then go to IDLE.
- Single-word transaction: SS is low for (2*WIDTH+2)*CLK_DIV cycles. Accept-to-accept spacing is (2*WIDTH+3)*CLK_DIV+1 cycles.
- IO0_O holds its last driven bit between words; it returns to 0 only on reset.
- rx_valid and a tx accept may coincide (WAIT entry cycle); both take effect.
- tx_valid outside IDLE/WAIT is ignored. tx_data may change freely while tx_ready=0.
- Reset mid-transfer: outputs return to reset values immediately (async). SS_O rises with no trailing edge, and no rx_valid is produced for the partial word.

Decomposition:
- Shared package spi_pkg holds:
  - state enum (IDLE, LEAD, SHIFT, WAIT, TRAIL, GAP)
  - CPOL=0 and CPHA=1 constants
  - localparam function for the edge_cnt width, $clog2(2*WIDTH)
- One natural sub-module: spi_master_clkgen, containing div_cnt plus the tick and SCK toggle register, with clear and enable inputs.
- Shift registers and the FSM live in spi_master.

Test Plan:
- WIDTH=8, CLK_DIV=4, tx 0xA5 with last=1, slave model returning 0x3C → SS low for 72 cycles, 8 rising SCK edges, MOSI bits 1,0,1,0,0,1,0,1, rx_data=0x3C with one rx_valid pulse.
- Burst 0x12 (last=0) then 0x34 (last=1), presented back-to-back, slave returning 0xAB, 0xCD → SS continuous low, 16 rising edges, rx_valid twice (0xAB, 0xCD), single SS rising edge.
- Burst with tx_valid withheld 50 cycles after the first word → block waits in WAIT with SS=0, SCK=0, tx_ready=1, busy=1; it resumes exactly CLK_DIV cycles before the next rising edge.
- Two single words 0xFF then 0x00, each with last=1 → SS high for at least CLK_DIV cycles between them, and tx_ready low during that gap.
- rst_n pulsed low mid-SHIFT (edge 7) → SS_O=1, SCK_O=0 at once, no rx_valid; a new word 0x5A afterwards transfers correctly.
- WIDTH=32, CLK_DIV=2, tx 0xDEADBEEF looped back MOSI→MISO → rx_data=0xDEADBEEF and SCK period=4 clk.
